// File: rtl/gpio_pattern_sequencer.sv
// rtl/gpio_pattern_sequencer.sv - CPU-programmed GPIO pattern sequencer with registered master port
//
// Purpose: the CPU loads a small pattern table, a period and a last index.
// On START the block writes the GPIO direction register once (all outputs).
// It then writes pattern[0..LAST] to the GPIO data register, one entry every
// max(PERIOD,1) cycles, either once (then done + irq) or looping until STOP.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_sel/i_we/i_addr     CPU register access (write taken when i_sel & i_we)
//   i_wdata/o_rdata       CPU write data / combinational read data
//   m_sel/m_we/m_addr     registered master cycle toward the GPIO control block
//   m_wdata               registered master write data
//   o_busy                high whenever the sequencer is not IDLE
//   o_done_irq            one-cycle pulse on normal (non-STOP) completion
//
// CPU map: 0x0 CTRL, 0x4 STATUS, 0x8 PERIOD, 0xC PAT (write only).

module gpio_pattern_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int GPIO_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_sel,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  m_sel,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  o_busy,
    output logic                  o_done_irq
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(4'h4);
    localparam logic [ADDR_WIDTH-1:0] OFF_PERIOD = ADDR_WIDTH'(4'h8);
    localparam logic [ADDR_WIDTH-1:0] OFF_PAT    = ADDR_WIDTH'(4'hC);

    // Offsets inside the GPIO control block targeted by the master port.
    localparam logic [ADDR_WIDTH-1:0] GPIO_DATA_OFF = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] GPIO_DIR_OFF  = ADDR_WIDTH'(4'h4);
    localparam logic [DATA_WIDTH-1:0] DIR_ALL_OUT   = DATA_WIDTH'({GPIO_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SET_DIR = 2'd1,
        WR_DATA = 2'd2,
        WAIT    = 2'd3
    } state_t;

    // CPU-visible configuration
    logic                  loop_q;
    logic [IDX_W-1:0]      last_q;
    logic [15:0]           period_q;
    logic [GPIO_WIDTH-1:0] pat_q [DEPTH];

    // Sequencer state
    state_t                state_q;
    logic [IDX_W-1:0]      index_q;
    logic [15:0]           cnt_q;
    logic                  done_q;

    // Registered master port and irq
    logic                  m_sel_q;
    logic                  m_we_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [DATA_WIDTH-1:0] m_wdata_q;
    logic                  irq_q;

    // ------------------------------------------------------------------
    // CPU access decode
    // ------------------------------------------------------------------
    logic wr_en;
    logic rd_en;
    logic ctrl_wr;
    logic start_req;
    logic stop_req;

    assign wr_en     = i_sel & i_we;
    assign rd_en     = i_sel & ~i_we & ~reset;
    assign ctrl_wr   = wr_en & (i_addr == OFF_CTRL);
    assign start_req = ctrl_wr & i_wdata[0];
    assign stop_req  = ctrl_wr & i_wdata[2];

    // Only a few write-data bits are meaningful; the rest are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, i_wdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loop_q   <= 1'b0;
            last_q   <= '0;
            period_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pat_q[i] <= '0;
            end
        end else if (wr_en) begin
            case (i_addr)
                OFF_CTRL: begin
                    loop_q <= i_wdata[1];
                    last_q <= i_wdata[8 +: IDX_W];
                end
                OFF_PERIOD: period_q <= i_wdata[15:0];
                OFF_PAT:    pat_q[i_wdata[8 +: IDX_W]] <= i_wdata[GPIO_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, zero when not a read)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (rd_en) begin
            case (i_addr)
                OFF_CTRL: begin
                    rd_val[1]          = loop_q;
                    rd_val[8 +: IDX_W] = last_q;
                end
                OFF_STATUS: begin
                    rd_val[0]          = (state_q != IDLE);
                    rd_val[1]          = done_q;
                    rd_val[4 +: IDX_W] = index_q;
                end
                OFF_PERIOD: rd_val[15:0] = period_q;
                default: ;
            endcase
        end
    end

    assign o_rdata = rd_val;

    // ------------------------------------------------------------------
    // Step / counter helpers
    // ------------------------------------------------------------------
    // WAIT covers PERIOD-1 cycles between data writes; PERIOD 0 and 1 both
    // load zero so the next write follows on the very next cycle.
    logic [15:0]      cnt_load;
    logic             at_last;
    logic [IDX_W-1:0] step_idx;
    logic             step_now;

    assign cnt_load = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;

    // ">=" rather than "==" so that shrinking LAST mid-run cannot let the
    // index run past the new end of the table.
    assign at_last  = (index_q >= last_q);
    assign step_idx = at_last ? '0 : index_q + 1'b1;

    assign step_now = ((state_q == WR_DATA) && (cnt_load == 16'd0)) ||
                      ((state_q == WAIT) && (cnt_q == 16'd1));

    // ------------------------------------------------------------------
    // Sequencer FSM. Master registers are loaded on the edge that enters
    // SET_DIR / WR_DATA, so each master cycle lines up with its state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            m_sel_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            m_sel_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            irq_q     <= 1'b0;

            if (stop_req) begin
                // STOP beats a simultaneous START and leaves done untouched.
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_req) begin
                            state_q   <= SET_DIR;
                            index_q   <= '0;
                            done_q    <= 1'b0;
                            m_sel_q   <= 1'b1;
                            m_we_q    <= 1'b1;
                            m_addr_q  <= GPIO_DIR_OFF;
                            m_wdata_q <= DIR_ALL_OUT;
                        end
                    end
                    SET_DIR: begin
                        state_q   <= WR_DATA;
                        m_sel_q   <= 1'b1;
                        m_we_q    <= 1'b1;
                        m_addr_q  <= GPIO_DATA_OFF;
                        m_wdata_q <= DATA_WIDTH'(pat_q[index_q]);
                    end
                    WR_DATA: begin
                        cnt_q <= cnt_load;
                        if (cnt_load != 16'd0) begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                    default: state_q <= IDLE;
                endcase

                if (step_now) begin
                    if (at_last && !loop_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                    end else begin
                        state_q   <= WR_DATA;
                        index_q   <= step_idx;
                        m_sel_q   <= 1'b1;
                        m_we_q    <= 1'b1;
                        m_addr_q  <= GPIO_DATA_OFF;
                        m_wdata_q <= DATA_WIDTH'(pat_q[step_idx]);
                    end
                end
            end
        end
    end

    assign m_sel      = m_sel_q;
    assign m_we       = m_we_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign o_done_irq = irq_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// tb/tb_gpio_pattern_sequencer.sv - self-checking bench for gpio_pattern_sequencer

module tb_gpio_pattern_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_sel;
    logic        i_we;
    logic [3:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        m_sel;
    logic        m_we;
    logic [3:0]  m_addr;
    logic [31:0] m_wdata;
    logic        o_busy;
    logic        o_done_irq;

    always #5 clk = ~clk;

    gpio_pattern_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .i_sel      (i_sel),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .m_sel      (m_sel),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .o_busy     (o_busy),
        .o_done_irq (o_done_irq)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [31:0] data;
    } mexp_t;

    typedef struct {
        logic        sel;
        logic [3:0]  addr;
        logic [31:0] exp;
    } rvec_t;

    mexp_t      exp_q [$];
    mexp_t      mon_e;
    rvec_t      vec [11];
    logic [3:0] exp_pat [8];
    int         checks  = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         irq_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every master cycle must match the next expected write,
    // including the cycle it appears in; idle cycles must be all zero.
    always @(negedge clk) begin
        if (o_done_irq) irq_cnt++;
        if (m_sel) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL master_unexpected actual addr=%h data=%h cyc=%0d required=no master cycle",
                         m_addr, m_wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("m_cyc",   cyc,           mon_e.cyc);
                chk("m_we",    32'(m_we),     32'd1);
                chk("m_addr",  32'(m_addr),   32'(mon_e.addr));
                chk("m_wdata", m_wdata,       mon_e.data);
            end
        end else begin
            chk("m_idle_zero", {27'd0, m_we, m_addr} | m_wdata, 32'd0);
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        i_sel   = 1'b1;
        i_we    = 1'b1;
        i_addr  = a;
        i_wdata = d;
        @(negedge clk);
        i_sel   = 1'b0;
        i_we    = 1'b0;
        i_addr  = 4'h0;
        i_wdata = 32'h0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
        i_sel  = 1'b1;
        i_we   = 1'b0;
        i_addr = a;
        #1;
        d      = o_rdata;
        i_sel  = 1'b0;
        i_addr = 4'h0;
    endtask

    task automatic pat_write(input int idx, input logic [3:0] val);
        exp_pat[idx] = val;
        cpu_write(4'hC, (32'(idx) << 8) | 32'(val));
    endtask

    // Queue the DIR write at s and n DATA writes spaced p cycles apart.
    task automatic start_seq(input logic [31:0] ctrl, input int p, input int last,
                             input int n, output int s);
        mexp_t e;
        s = cyc + 1;
        e.cyc = s; e.addr = 4'h4; e.data = 32'hF;
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            e.cyc  = s + 1 + k * p;
            e.addr = 4'h0;
            e.data = 32'(exp_pat[k % (last + 1)]);
            exp_q.push_back(e);
        end
        cpu_write(4'h0, ctrl);
    endtask

    task automatic wait_irq(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_done_irq) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            i_sel  = vec[i].sel;
            i_we   = 1'b0;
            i_addr = vec[i].addr;
            #1;
            chk($sformatf("rd_vec%0d", i), o_rdata, vec[i].exp);
            i_sel  = 1'b0;
            i_addr = 4'h0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          s;
        int          at;
        int          irq_before;
        logic [31:0] rd;

        vec[0]  = '{1'b1, 4'h0, 32'h0000_0300};
        vec[1]  = '{1'b1, 4'h4, 32'h0000_0032};
        vec[2]  = '{1'b1, 4'h8, 32'h0000_0005};
        vec[3]  = '{1'b1, 4'hC, 32'h0000_0000};
        vec[4]  = '{1'b1, 4'h2, 32'h0000_0000};
        vec[5]  = '{1'b0, 4'h4, 32'h0000_0000};
        vec[6]  = '{1'b0, 4'h8, 32'h0000_0000};
        vec[7]  = '{1'b1, 4'hF, 32'h0000_0000};
        vec[8]  = '{1'b1, 4'h0, 32'h0000_0000};
        vec[9]  = '{1'b1, 4'h4, 32'h0000_0000};
        vec[10] = '{1'b1, 4'h8, 32'h0000_0000};
        for (int i = 0; i < 8; i++) exp_pat[i] = 4'h0;

        reset   = 1'b1;
        i_sel   = 1'b0;
        i_we    = 1'b0;
        i_addr  = 4'h0;
        i_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", 32'(o_busy),     32'd0);
        chk("rst_msel", 32'(m_sel),      32'd0);
        chk("rst_irq",  32'(o_done_irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(8, 10);

        // Single pass, PERIOD=5 (upper bits of the write are dropped)
        for (int i = 0; i < 4; i++) pat_write(i, 4'(1 << i));
        cpu_write(4'h8, 32'h0001_0005);
        start_seq(32'h0000_0301, 5, 3, 4, s);
        wait_irq(60, at);
        chk("t1_irq_cyc", at, s + 21);
        @(negedge clk);
        chk("t1_irq_width", 32'(o_done_irq), 32'd0);
        run_vec(0, 7);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // PERIOD=0 behaves as 1: back-to-back data writes
        cpu_write(4'h8, 32'h0);
        start_seq(32'h0000_0101, 1, 1, 2, s);
        wait_irq(20, at);
        chk("t2_irq_cyc", at, s + 3);
        @(negedge clk);
        cpu_read(4'h4, rd);
        chk("t2_status", rd, 32'h12);

        // STOP together with START while idle: nothing starts, done kept
        cpu_write(4'h0, 32'h0000_0105);
        chk("stopstart_busy", 32'(o_busy), 32'd0);
        cpu_read(4'h4, rd);
        chk("stopstart_status", rd, 32'h12);

        // Looping run, then STOP between data writes
        irq_before = irq_cnt;
        cpu_write(4'h8, 32'd3);
        start_seq(32'h0000_0103, 3, 1, 6, s);
        wait_cyc(s + 16);
        cpu_write(4'h0, 32'h0000_0106);
        repeat (8) @(negedge clk);
        chk("t3_busy", 32'(o_busy), 32'd0);
        cpu_read(4'h4, rd);
        chk("t3_status", rd, 32'h10);
        chk("t3_no_irq", irq_cnt, irq_before);
        chk("t3_queue_empty", exp_q.size(), 32'd0);

        // START while busy is ignored; PAT write while busy used at next WR_DATA
        cpu_write(4'h8, 32'd4);
        exp_pat[3] = 4'h5;
        start_seq(32'h0000_0301, 4, 3, 4, s);
        wait_cyc(s + 5);
        cpu_write(4'h0, 32'h0000_0301);
        cpu_write(4'hC, 32'h0000_0305);
        cpu_read(4'h4, rd);
        chk("t4_status_mid", rd, 32'h11);
        wait_irq(40, at);
        chk("t4_irq_cyc", at, s + 17);
        chk("t4_queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset during WAIT
        cpu_write(4'h8, 32'd10);
        start_seq(32'h0000_0301, 10, 3, 1, s);
        wait_cyc(s + 3);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_busy_async", 32'(o_busy), 32'd0);
        chk("t5_msel_async", 32'(m_sel),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_pat[i] = 4'h0;
        run_vec(8, 10);
        repeat (15) @(negedge clk);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

        // After reset the table and PERIOD are zero: one zero data write, then done
        start_seq(32'h0000_0001, 1, 0, 1, s);
        wait_irq(20, at);
        chk("t6_irq_cyc", at, s + 2);
        repeat (3) @(negedge clk);
        chk("t6_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_pattern_sequencer.md
GPIO_PATTERN_SEQUENCER -- requirements
Module: gpio_pattern_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ADDR_WIDTH 4 bus offset width; DATA_WIDTH 32 bus data width; GPIO_WIDTH 4 pins driven; DEPTH 8 pattern entries (index 3 bits).
REQ-002 Ports (name, direction, width, meaning) SHALL be, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- i_sel  in  1  CPU chip select.
- i_we  in  1  CPU write enable.
- i_addr  in  ADDR_WIDTH  CPU register offset.
- i_wdata  in  DATA_WIDTH  CPU write data.
- o_rdata  out  DATA_WIDTH  CPU read data, combinational.
- m_sel  out  1  master select to GPIO control block.
- m_we  out  1  master write enable.
- m_addr  out  ADDR_WIDTH  master offset.
- m_wdata  out  DATA_WIDTH  master write data.
- o_busy  out  1  sequence running.
- o_done_irq  out  1  one-cycle pulse at normal completion.

Function
REQ-003 CPU map SHALL be: 0x0 CTRL (W: bit0 START pulse, bit1 LOOP, bit2 STOP pulse, bits[10:8] LAST index; R: LOOP, LAST, START/STOP read 0); 0x4 STATUS (R only: bit0 busy, bit1 done sticky, bits[6:4] current index); 0x8 PERIOD (R/W, bits[15:0]); 0xC PAT (W only: bits[10:8] entry index, bits[GPIO_WIDTH-1:0] pattern; R returns 0).
REQ-004 o_rdata SHALL equal the addressed register zero-extended when i_sel=1 and i_we=0, and 0 otherwise, including unmapped offsets.
REQ-005 A write is taken in the cycle i_sel=1 and i_we=1; unmapped offsets SHALL be ignored.
REQ-006 FSM states SHALL be IDLE, SET_DIR, WR_DATA, WAIT.
REQ-007 IDLE: START write -> SET_DIR next cycle, index=0, done cleared; START while not IDLE SHALL be ignored.
REQ-008 SET_DIR: exactly one master cycle m_sel=1, m_we=1, m_addr=0x4, m_wdata=GPIO_WIDTH ones (all outputs) -> WR_DATA.
REQ-009 WR_DATA: exactly one master cycle m_sel=1, m_we=1, m_addr=0x0, m_wdata=zero-extended pattern[index]; counter loaded PERIOD-1; -> WAIT if counter nonzero, else step directly.
REQ-010 WAIT: decrement counter per cycle; at 0 step.
REQ-011 Step: if index<LAST, index+1 and -> WR_DATA; if index=LAST and LOOP=1, index=0 and -> WR_DATA; if index=LAST and LOOP=0, -> IDLE, done set, o_done_irq pulsed 1 cycle.
REQ-012 Consecutive DATA writes SHALL be exactly max(PERIOD,1) cycles apart; PERIOD=0 SHALL behave as 1.
REQ-013 PERIOD and PAT writes while busy SHALL be accepted and take effect at the next WR_DATA.
REQ-014 STOP write SHALL force IDLE next cycle with no further master cycles, done unchanged, no o_done_irq; STOP and START in the same write: STOP wins.
REQ-015 Master outputs SHALL be registered; m_sel=0, m_we=0, m_addr=0, m_wdata=0 in every non-write cycle.
REQ-016 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-017 reset=1 SHALL immediately force IDLE; zero all registers, pattern table, counter, index, LOOP, LAST, PERIOD; drive all outputs 0; reset mid-sequence issues no further master cycles.

Verification
REQ-018 PAT 0..3 = 1,2,4,8, LAST=3, LOOP=0, PERIOD=5, START -> one DIR write 0xF, DATA writes 1,2,4,8 spaced 5 cycles, then one o_done_irq, STATUS=0x32.
REQ-019 PERIOD=0, LAST=1 -> DATA writes on consecutive cycles, then done.
REQ-020 LOOP=1, LAST=1, PERIOD=3 -> DATA writes alternate p0,p1,p0... indefinitely; STOP -> no master cycle after next edge, busy=0, done=0.
REQ-021 START written while busy -> ignored, index and sequence timing unchanged.
REQ-022 reset asserted during WAIT -> outputs 0 asynchronously; after release, CPU reads of 0x0, 0x4, 0x8 return 0.
REQ-023 Read of 0xC or unmapped 0x2, and any cycle with i_sel=0 -> o_rdata=0.
